// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular sharing of one UART transmitter
// Requesters hold the transmitter from grant until their last byte's tx_done or MAX_LEN bytes.
module uart_tx_arbiter #(
  parameter int N_REQ    = 2,
  parameter int DBITS    = 8,
  parameter int MAX_LEN  = 64,
  parameter int LEN_BITS = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DBITS-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   tx_start,
  output logic [DBITS-1:0]       tx_data,
  input  logic                   tx_done,
  output logic                   len_overrun
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic                win_found;
  logic [LEN_BITS-1:0] count;
  logic                last_q;
  logic [DBITS-1:0]    owner_data;
  logic                owner_valid;
  logic                owner_last;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan starts just after the last owner, so the previous winner is considered last.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_data  = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == owner) begin
        owner_data  = req_data[i*DBITS +: DBITS];
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
      end
    end
  end

  assign req_ready = (state == S_LOAD) ? (grant & req_valid) : '0;
  assign busy      = |grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      len_overrun <= 1'b0;
      count       <= '0;
      ptr         <= IDX_W'(N_REQ - 1);
      owner       <= '0;
      last_q      <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      len_overrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant <= onehot(win_idx);
            owner <= win_idx;
            count <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A stalled owner keeps the line; other requesters are never interleaved.
          if (owner_valid) begin
            tx_data  <= owner_data;
            tx_start <= 1'b1;
            last_q   <= owner_last;
            count    <= count + LEN_BITS'(1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            if (last_q) begin
              grant <= '0;
              ptr   <= owner;
              state <= S_IDLE;
            end else if (count == LEN_BITS'(MAX_LEN)) begin
              grant       <= '0;
              ptr         <= owner;
              len_overrun <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
